// File: rtl/dsp_mac_lanes.sv
// -----------------------------------------------------------------------------
// dsp_mac_lanes
//   Multi-lane signed multiply-accumulate unit. LANES independent signed
//   A x B products are formed in parallel and summed per lane over a frame
//   delimited by in_first / in_last. The frame result is offered on a
//   valid/ready port whose back-pressure stalls the whole pipeline.
//
//   Pipeline: S1 operand register -> S2 product register (zero-skip)
//             -> S3 accumulator FSM -> output register.
//   The last beat accepted at edge t shows up as out_valid=1 after edge t+3.
//
// Ports
//   clk        clock
//   rst_n      asynchronous reset, active-high (registers clear while rst_n=1)
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_a       lane i operand A at [i*A_WIDTH +: A_WIDTH], signed
//   in_b       lane i operand B at [i*B_WIDTH +: B_WIDTH], signed
//   in_first   beat starts a new frame
//   in_last    beat ends the frame
//   out_valid  frame result valid
//   out_ready  consumer accepts result
//   out_acc    lane i accumulated sum at [i*ACC_WIDTH +: ACC_WIDTH], signed
//   out_beats  beats in the frame, saturating at 16'hFFFF
//   out_sat    per-lane sticky saturation flag for the frame
//
// Build option
//   DSP_MAC_SATURATE_EN : when defined, each lane clamps on accumulate
//   overflow and raises its sticky out_sat bit; otherwise sums wrap modulo
//   2^ACC_WIDTH and out_sat stays 0.
// -----------------------------------------------------------------------------
module dsp_mac_lanes #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LANES     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*A_WIDTH-1:0]   in_a,
  input  logic [LANES*B_WIDTH-1:0]   in_b,
  input  logic                       in_first,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out_acc,
  output logic [15:0]                out_beats,
  output logic [LANES-1:0]           out_sat
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  // Parameter sanity: the accumulator must hold at least one full product.
  if (ACC_WIDTH < P_WIDTH) begin : g_bad_acc_width
    $error("dsp_mac_lanes: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("dsp_mac_lanes: LANES must be >= 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Global advance enable: everything holds while a result waits unaccepted.
  logic w_en;
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  // Stage 1 registers
  logic                     r_s1_valid;
  logic                     r_s1_first;
  logic                     r_s1_last;
  logic [LANES*A_WIDTH-1:0] r_s1_a;
  logic [LANES*B_WIDTH-1:0] r_s1_b;

  // Stage 2 registers
  logic                     r_s2_valid;
  logic                     r_s2_first;
  logic                     r_s2_last;
  logic [LANES*P_WIDTH-1:0] r_s2_prod;

  // Stage 3 (accumulator) registers
  state_t                     r_state;
  logic [LANES*ACC_WIDTH-1:0] r_acc;
  logic [15:0]                r_beats;
  logic [LANES-1:0]           r_sat;
  logic                       r_s3_fin;

  // Per-lane combinational results
  logic [LANES*P_WIDTH-1:0]   w_prod;
  logic [LANES*ACC_WIDTH-1:0] w_start_acc;
  logic [LANES*ACC_WIDTH-1:0] w_sum_acc;
  logic [LANES-1:0]           w_sum_sat;
  logic                       w_start;

`ifdef DSP_MAC_SATURATE_EN
  localparam int SUM_W = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [A_WIDTH-1:0]   w_a;
    logic signed [B_WIDTH-1:0]   w_b;
    logic signed [P_WIDTH-1:0]   w_mul;
    logic signed [P_WIDTH-1:0]   w_prod_lane;
    logic signed [ACC_WIDTH-1:0] w_acc_lane;
    logic signed [ACC_WIDTH-1:0] w_pext;
    logic signed [ACC_WIDTH-1:0] w_add;
    logic                        w_add_sat;

    assign w_a   = r_s1_a[g*A_WIDTH +: A_WIDTH];
    assign w_b   = r_s1_b[g*B_WIDTH +: B_WIDTH];
    assign w_mul = P_WIDTH'(w_a) * P_WIDTH'(w_b);

    // Zero-skip: a zero operand bypasses the multiplier result entirely.
    assign w_prod[g*P_WIDTH +: P_WIDTH] =
        ((w_a == '0) || (w_b == '0)) ? '0 : w_mul;

    assign w_prod_lane = r_s2_prod[g*P_WIDTH +: P_WIDTH];
    assign w_pext      = ACC_WIDTH'(w_prod_lane);
    assign w_acc_lane  = r_acc[g*ACC_WIDTH +: ACC_WIDTH];

`ifdef DSP_MAC_SATURATE_EN
    logic signed [ACC_WIDTH:0] w_sum;
    assign w_sum = SUM_W'(w_acc_lane) + SUM_W'(w_pext);

    // Clamp to the signed range when the two top sum bits disagree.
    always_comb begin
      w_add     = w_sum[ACC_WIDTH-1:0];
      w_add_sat = 1'b0;
      if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
        w_add     = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        w_add_sat = 1'b1;
      end else begin
        w_add     = w_sum[ACC_WIDTH-1:0];
        w_add_sat = 1'b0;
      end
    end
`else
    assign w_add     = w_acc_lane + w_pext;
    assign w_add_sat = 1'b0;
`endif

    assign w_start_acc[g*ACC_WIDTH +: ACC_WIDTH] = w_pext;
    assign w_sum_acc[g*ACC_WIDTH +: ACC_WIDTH]   = w_add;
    assign w_sum_sat[g]                          = w_add_sat;
  end

  // Stage 1: capture operands and beat flags.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_first <= in_first;
      r_s1_last  <= in_last;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
    end
  end

  // Stage 2: register the per-lane products.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_prod  <= w_prod;
    end
  end

  // A beat opens a fresh frame when flagged first or when no frame is open.
  always_comb begin
    w_start = 1'b1;
    case (r_state)
      ST_IDLE:  w_start = 1'b1;
      ST_ACCUM: w_start = r_s2_first;
      default:  w_start = 1'b1;
    endcase
  end

  // Stage 3: accumulator FSM; r_s3_fin marks a completed frame in r_acc.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_beats  <= 16'd0;
      r_sat    <= '0;
      r_s3_fin <= 1'b0;
    end else if (w_en) begin
      r_s3_fin <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        if (w_start) begin
          r_acc   <= w_start_acc;
          r_beats <= 16'd1;
          r_sat   <= '0;
        end else begin
          r_acc   <= w_sum_acc;
          r_beats <= (r_beats == 16'hFFFF) ? r_beats : r_beats + 16'd1;
          r_sat   <= r_sat | w_sum_sat;
        end
        r_state <= r_s2_last ? ST_IDLE : ST_ACCUM;
      end
    end
  end

  // Output register: when advancing, any held result has just been taken,
  // so out_valid simply follows whether a new frame completed.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_beats <= 16'd0;
      out_sat   <= '0;
    end else if (w_en) begin
      out_valid <= r_s3_fin;
      if (r_s3_fin) begin
        out_acc   <= r_acc;
        out_beats <= r_beats;
        out_sat   <= r_sat;
      end
    end
  end

endmodule
